register_file_sb: RTL and testbench

//  32-entry general-purpose register file with an integrated write-pending scoreboard.

---
 rtl/register_file_sb_pkg.sv | 12 +
 rtl/register_file_sb_scoreboard.sv | 31 +++
 rtl/register_file_sb.sv | 58 +++++
 tb/tb_register_file_sb.sv | 133 +++++++++++++
 4 files changed

// File: rtl/register_file_sb_pkg.sv
// register_file_sb_pkg: shared register-file constants, select/address types and the zero-register mask helper
package register_file_sb_pkg;
  localparam int REG_COUNT    = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int ZERO_REG_IDX = 0;
  typedef logic [REG_COUNT-1:0]  reg_sel_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  // Select mask that removes the hardwired zero register when it is enabled.
  function automatic reg_sel_t sel_mask(input bit zero_reg);
    return zero_reg ? ~(reg_sel_t'(1) << ZERO_REG_IDX) : '1;
  endfunction
endpackage

// File: rtl/register_file_sb_scoreboard.sv
// register_scoreboard: write-pending Busy vector with set-over-clear priority and per-port stall flags
//   clk, rst            clock, synchronous active-high reset
//   issue_en_i/sel_i    destination issue (marks pending)
//   clr_i               writeback hits, already gated by write enable
//   rd_addr_a/b_i       read port sources
//   stall_a/b_o         source pending and not resolved this cycle
//   busy_o              registered scoreboard vector
module register_scoreboard
  import register_file_sb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      issue_en_i,
  input  reg_sel_t  issue_sel_i,
  input  reg_sel_t  clr_i,
  input  reg_addr_t rd_addr_a_i,
  input  reg_addr_t rd_addr_b_i,
  output logic      stall_a_o,
  output logic      stall_b_o,
  output reg_sel_t  busy_o
);
  reg_sel_t busy_q, busy_d;
  // A new producer supersedes the retiring one, so set wins over clear.
  always_comb busy_d = ({REG_COUNT{issue_en_i}} & issue_sel_i) | (busy_q & ~clr_i);
  always_ff @(posedge clk)
    busy_q <= rst ? '0 : busy_d;
  // A writeback landing this cycle resolves the hazard through the bypass.
  assign stall_a_o = busy_q[rd_addr_a_i] & ~clr_i[rd_addr_a_i] & ~rst;
  assign stall_b_o = busy_q[rd_addr_b_i] & ~clr_i[rd_addr_b_i] & ~rst;
  assign busy_o    = busy_q;
endmodule

// File: rtl/register_file_sb.sv
// register_file_sb: 32-entry register file with write bypass and write-pending scoreboard
//   clk, reset            clock, synchronous active-high reset
//   WrEn/WrSel/WrData     one-hot writeback
//   IssueEn/IssueSel      one-hot destination issue
//   RdAddrA/B -> RdDataA/B combinational reads with same-cycle bypass
//   StallA/B              per-port hazard flags, Busy registered scoreboard
module register_file_sb
  import register_file_sb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             WrEn,
  input  logic [31:0]      WrSel,
  input  logic [WIDTH-1:0] WrData,
  input  logic             IssueEn,
  input  logic [31:0]      IssueSel,
  input  logic [4:0]       RdAddrA,
  input  logic [4:0]       RdAddrB,
  output logic [WIDTH-1:0] RdDataA,
  output logic [WIDTH-1:0] RdDataB,
  output logic             StallA,
  output logic             StallB,
  output logic [31:0]      Busy
);
  localparam reg_sel_t MASK = sel_mask(ZERO_REG);
  logic [WIDTH-1:0] mem_q [REG_COUNT];
  logic [WIDTH-1:0] mem_d [REG_COUNT];
  reg_sel_t wr_hit;
  reg_sel_t byp_hit;
  assign wr_hit  = WrSel & MASK & {REG_COUNT{WrEn}};
  assign byp_hit = wr_hit & {REG_COUNT{~reset}};
  always_comb
    for (int i = 0; i < REG_COUNT; i++)
      mem_d[i] = wr_hit[i] ? WrData : mem_q[i];
  always_ff @(posedge clk)
    for (int i = 0; i < REG_COUNT; i++)
      mem_q[i] <= reset ? '0 : mem_d[i];
  function automatic logic [WIDTH-1:0] rd(input reg_addr_t a);
    return (ZERO_REG && a == REG_ADDR_W'(ZERO_REG_IDX)) ? '0 : byp_hit[a] ? WrData : mem_q[a];
  endfunction
  assign RdDataA = rd(RdAddrA);
  assign RdDataB = rd(RdAddrB);
  register_scoreboard u_sb (
    .clk         (clk),
    .rst         (reset),
    .issue_en_i  (IssueEn),
    .issue_sel_i (IssueSel & MASK),
    .clr_i       (wr_hit),
    .rd_addr_a_i (RdAddrA),
    .rd_addr_b_i (RdAddrB),
    .stall_a_o   (StallA),
    .stall_b_o   (StallB),
    .busy_o      (Busy)
  );
endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: directed checks of register_file_sb storage, bypass, zero register and scoreboard
module tb_register_file_sb;
  logic        clk = 0;
  logic        reset = 1;
  logic        WrEn = 0;
  logic [31:0] WrSel = 0;
  logic [31:0] WrData = 0;
  logic        IssueEn = 0;
  logic [31:0] IssueSel = 0;
  logic [4:0]  RdAddrA = 5;
  logic [4:0]  RdAddrB = 0;
  logic [31:0] RdDataA, RdDataB, Busy;
  logic        StallA, StallB;
  int total = 0;
  int bad = 0;
  register_file_sb #(.WIDTH(32), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .WrEn(WrEn), .WrSel(WrSel), .WrData(WrData),
    .IssueEn(IssueEn), .IssueSel(IssueSel), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
    .RdDataA(RdDataA), .RdDataB(RdDataB), .StallA(StallA), .StallB(StallB), .Busy(Busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (!reset && WrEn && !$onehot0(WrSel)) $error("multi-hot WrSel %h", WrSel);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle();
    WrEn = 0; WrSel = 0; IssueEn = 0; IssueSel = 0;
  endtask
  initial begin
    tick();
    #1;
    check("rst_rd_a5", RdDataA, 32'h0);
    check("rst_busy", Busy, 32'h0);
    check("rst_stall_a", {31'b0, StallA}, 32'h0);
    WrEn = 1; WrSel = 32'h8; WrData = 32'hFFFF; RdAddrB = 3;
    #1;
    check("rst_no_bypass", RdDataB, 32'h0);
    tick();
    reset = 0; idle();
    #1;
    check("rst_r3_kept", RdDataB, 32'h0);
    WrEn = 1; WrSel = 32'h8; WrData = 32'hDEADBEEF; RdAddrA = 4;
    #1;
    check("bypass_b3", RdDataB, 32'hDEADBEEF);
    check("no_bypass_a4", RdDataA, 32'h0);
    tick();
    idle(); RdAddrA = 3;
    #1;
    check("read_a3", RdDataA, 32'hDEADBEEF);
    WrEn = 1; WrSel = 32'h1; WrData = 32'h1234; IssueEn = 1; IssueSel = 32'h1; RdAddrA = 0;
    #1;
    check("r0_bypass_zero", RdDataA, 32'h0);
    tick();
    idle();
    #1;
    check("r0_read_zero", RdDataA, 32'h0);
    check("r0_not_busy", Busy, 32'h0);
    IssueEn = 1; IssueSel = 32'h20;
    tick();
    idle(); RdAddrA = 5;
    #1;
    check("haz_busy5", Busy, 32'h20);
    check("haz_stall1", {31'b0, StallA}, 32'h1);
    tick();
    #1;
    check("haz_stall2", {31'b0, StallA}, 32'h1);
    WrEn = 1; WrSel = 32'h20; WrData = 32'h55AA;
    #1;
    check("haz_wb_stall", {31'b0, StallA}, 32'h0);
    check("haz_wb_data", RdDataA, 32'h55AA);
    tick();
    idle();
    #1;
    check("haz_cleared", Busy, 32'h0);
    check("haz_stored", RdDataA, 32'h55AA);
    check("haz_no_stall", {31'b0, StallA}, 32'h0);
    IssueEn = 1; IssueSel = 32'h80;
    tick();
    idle(); RdAddrB = 7;
    #1;
    check("col_busy7", Busy, 32'h80);
    WrEn = 1; WrSel = 32'h80; WrData = 32'h7777; IssueEn = 1; IssueSel = 32'h80;
    #1;
    check("col_stall_wb", {31'b0, StallB}, 32'h0);
    tick();
    idle();
    #1;
    check("col_busy_kept", Busy, 32'h80);
    check("col_r7", RdDataB, 32'h7777);
    check("col_stall_after", {31'b0, StallB}, 32'h1);
    WrEn = 1; WrSel = 32'h80; WrData = 32'h0;
    tick();
    idle();
    for (int i = 8; i < 12; i++) begin
      IssueEn = 1; IssueSel = 32'h1 << i;
      tick();
    end
    idle();
    #1;
    check("mid_busy_f00", Busy, 32'h0000_0F00);
    RdAddrA = 9; RdAddrB = 3;
    WrEn = 1; WrSel = 32'h200; WrData = 32'hAAAA; reset = 1;
    #1;
    check("mid_rst_stall", {31'b0, StallA}, 32'h0);
    check("mid_rst_no_bypass", RdDataA, 32'h0);
    tick();
    reset = 0; idle();
    #1;
    check("mid_busy_clr", Busy, 32'h0);
    check("mid_r9_discard", RdDataA, 32'h0);
    check("mid_r3_clr", RdDataB, 32'h0);
    RdAddrA = 5; RdAddrB = 7;
    #1;
    check("mid_r5_clr", RdDataA, 32'h0);
    check("mid_r7_clr", RdDataB, 32'h0);
    WrEn = 1; WrSel = 32'h0; WrData = 32'hBEEF;
    tick();
    idle();
    #1;
    check("noop_r5", RdDataA, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
